// File: rtl/puf_resp_readout.sv
// Captures an XOR-PUF response on each DONE rising edge and serves it to the
// SPI slave one byte per request, MSB byte first, with capture count and overrun flag.
module puf_resp_readout #(
  parameter int         WIDTH     = 128,
  parameter logic [7:0] READ_CODE = 8'd3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       CODE,
  input  logic             DONE,
  input  logic [WIDTH-1:0] PUF_IN,
  input  logic             BYTE_REQ,
  input  logic             CLR,
  output logic [7:0]       BYTE_OUT,
  output logic             BYTE_VALID,
  output logic             READY,
  output logic             OVERRUN,
  output logic [15:0]      RESP_CNT
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADED  = 2'd1,
    ST_READING = 2'd2,
    ST_DRAINED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] resp_q, resp_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             ovr_q, ovr_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             done_dq;
  logic             done_rise_s;
  logic             rd_en_s;
  logic [15:0]      cnt_base_s;

  // Byte b of the response, byte 0 being the most significant.
  function automatic logic [7:0] byte_sel(input logic [WIDTH-1:0] data,
                                          input logic [IDXW-1:0]  idx);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < NBYTES; b++) begin
      if (idx == IDXW'(b)) r = data[WIDTH-1-8*b -: 8];
    end
    return r;
  endfunction

  assign done_rise_s = DONE & ~done_dq;
  assign rd_en_s     = (CODE == READ_CODE);
  assign cnt_base_s  = CLR ? 16'h0000 : cnt_q;

  // State register and all registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_EMPTY;
      resp_q  <= '0;
      idx_q   <= '0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= 16'h0000;
      done_dq <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
      done_dq <= DONE;
    end
  end

  // Next-state, capture and byte-serving logic.
  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ovr_d   = CLR ? 1'b0 : ovr_q;
    cnt_d   = cnt_base_s;

    case (state_q)
      ST_EMPTY, ST_DRAINED: begin
        // Nothing held: requests are answered with a zero byte.
        if (BYTE_REQ && rd_en_s) begin
          valid_d = 1'b1;
          byte_d  = 8'h00;
        end else begin
          valid_d = 1'b0;
        end
        if (done_rise_s) begin
          resp_d  = PUF_IN;
          idx_d   = '0;
          cnt_d   = (cnt_base_s == 16'hFFFF) ? cnt_base_s : cnt_base_s + 16'd1;
          state_d = ST_LOADED;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOADED: begin
        if (done_rise_s) ovr_d = 1'b1;
        else             ovr_d = ovr_d;
        if (BYTE_REQ && rd_en_s) begin
          valid_d = 1'b1;
          byte_d  = byte_sel(resp_q, '0);
          idx_d   = IDXW'(1);
          state_d = (NBYTES == 1) ? ST_DRAINED : ST_READING;
        end else begin
          state_d = ST_LOADED;
        end
      end
      ST_READING: begin
        if (done_rise_s) ovr_d = 1'b1;
        else             ovr_d = ovr_d;
        // Leaving the read command rewinds to byte 0 but keeps the data.
        if (!rd_en_s) begin
          idx_d   = '0;
          state_d = ST_LOADED;
        end else if (BYTE_REQ) begin
          valid_d = 1'b1;
          byte_d  = byte_sel(resp_q, idx_q);
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_DRAINED;
          end else begin
            idx_d   = idx_q + IDXW'(1);
            state_d = ST_READING;
          end
        end else begin
          state_d = ST_READING;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        idx_d   = '0;
      end
    endcase

    ready_d = (state_d == ST_LOADED) || (state_d == ST_READING);
  end

  assign BYTE_OUT   = byte_q;
  assign BYTE_VALID = valid_q;
  assign READY      = ready_q;
  assign OVERRUN    = ovr_q;
  assign RESP_CNT   = cnt_q;

endmodule

// File: doc/puf_resp_readout.md
Name: puf_resp_readout

Overview:
- Sits directly downstream of the XOR-PUF stimulus controller.
- Captures the 128-bit PUF response on each rising edge of the controller's DONE.
- Holds the response and hands it to the SPI slave one byte at a time, MSB byte first, via a request/valid handshake while the read command code is active.
- Tracks a capture count and a sticky overrun flag for lost responses.

Parameters:
- WIDTH, 128, response width in bits; must be a multiple of 8.
- READ_CODE, 8'd3, CODE value that enables byte readout.
- NBYTES, WIDTH/8, derived local value: bytes per response.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- CODE  input  8  command code from the SPI register block.
- DONE  input  1  response-ready level from the stimulus controller.
- PUF_IN  input  WIDTH  registered PUF response from the stimulus controller.
- BYTE_REQ  input  1  one-cycle pulse from the SPI slave requesting the next byte.
- CLR  input  1  synchronous clear of RESP_CNT and OVERRUN.
- BYTE_OUT  output  8  byte returned to the SPI slave.
- BYTE_VALID  output  1  one-cycle pulse; BYTE_OUT is valid in this cycle.
- READY  output  1  an unread or partially read response is held.
- OVERRUN  output  1  sticky flag: a DONE edge arrived while a response was still held.
- RESP_CNT  output  16  count of accepted captures; saturates at 16'hFFFF.

Behaviour:
- Reset, asynchronous on RESET=1:
  - State EMPTY.
  - Shift register, byte index, BYTE_OUT, BYTE_VALID, READY, OVERRUN, RESP_CNT and the DONE delay flop all go to 0.
  - Reset mid-read discards the held response.
- Edge detect: done_rise = DONE & ~DONE_d, with DONE_d registered. A DONE level held high produces exactly one capture.
- States:
  - EMPTY: no data.
  - LOADED: data held, index 0.
  - READING: index 1..NBYTES-1.
  - DRAINED: all bytes delivered.
- Transitions:
  - EMPTY or DRAINED, done_rise: capture PUF_IN, index<=0, RESP_CNT+1 (saturating), go to LOADED.
  - LOADED, BYTE_REQ and CODE==READ_CODE: send byte 0 (PUF bits [WIDTH-1:WIDTH-8]), index<=1, go to READING.
  - READING, BYTE_REQ and CODE==READ_CODE: send byte[index], index+1.
    - After byte NBYTES-1 is sent, go to DRAINED.
  - READING and CODE!=READ_CODE for any cycle: abort to LOADED, index<=0. The next read restarts from byte 0; data is kept.
- Output timing:
  - BYTE_OUT and BYTE_VALID are registered and appear the cycle after BYTE_REQ (latency 1).
  - BYTE_OUT holds its value until the next served request.
- BYTE_REQ with CODE!=READ_CODE: ignored; no BYTE_VALID.
- BYTE_REQ with CODE==READ_CODE in EMPTY or DRAINED: BYTE_VALID pulses with BYTE_OUT=8'h00; no state change.
- READY is 1 in LOADED and READING, 0 otherwise; it is registered with the state.
- done_rise in LOADED or READING:
  - New data is dropped; OVERRUN<=1; RESP_CNT is unchanged.
  - A BYTE_REQ in the same cycle is still served normally.
  - If that cycle completes the last byte, the state goes to DRAINED and the dropped response is not recovered.
- CLR:
  - Clears OVERRUN and RESP_CNT only.
  - If CLR and an accepted capture occur in the same cycle, RESP_CNT ends at 1 and OVERRUN at 0.
  - If CLR and an overrun occur in the same cycle, OVERRUN ends at 1 (set wins).
- Consecutive BYTE_REQ on back-to-back cycles are each served; one byte per cycle is the maximum rate.

Test Plan:
- Reset, then pulse DONE with PUF_IN=128'h0123456789ABCDEF_FEDCBA9876543210, CODE=3, then 16 BYTE_REQ pulses -> READY=1 after capture; BYTE_OUT sequence 01,23,...,EF,FE,...,10, each one cycle after its request; READY=0 and state DRAINED after byte 16; RESP_CNT=1.
- Hold DONE high for 50 cycles -> exactly one capture; RESP_CNT=1; OVERRUN=0.
- After 5 bytes are read, drop CODE to 0 for one cycle, restore to 3, request again -> next byte is 8'h01 (restart from byte 0); READY stays 1.
- While LOADED, pulse DONE again with different PUF_IN -> OVERRUN=1; readout returns the original data; RESP_CNT unchanged. Then pulse CLR -> OVERRUN=0, RESP_CNT=0.
- BYTE_REQ with CODE=2 in LOADED -> no BYTE_VALID; BYTE_REQ with CODE=3 in EMPTY -> BYTE_VALID with BYTE_OUT=8'h00; assert RESET mid-read -> all outputs 0 and state EMPTY immediately (asynchronous).
